// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and transmitter-side signals of the shared UART transmit scheduler.
interface uart_tx_scheduler_if #(parameter int N_REQ = 4);
    logic               en;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         tx_i_data;
    logic               tx_i_data_valid;
    logic               tx_o_ready;
    logic               tx_en;
    logic               busy;
    logic               abort;

    modport master (
        output en, req_valid, req_data, req_last, tx_o_ready,
        input  req_ready, grant, tx_i_data, tx_i_data_valid, tx_en, busy, abort
    );
    modport slave (
        input  en, req_valid, req_data, req_last, tx_o_ready,
        output req_ready, grant, tx_i_data, tx_i_data_valid, tx_en, busy, abort
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin packet scheduler that shares one uart_tx among N_REQ byte producers.
// An owner keeps the transmitter until its last byte drains or it stalls TIMEOUT cycles.
module uart_tx_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {ARB, SEND, LOAD, DRAIN} state_t;

    state_t           state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    next_ptr;
    logic [N_REQ-1:0] grant;
    logic [CW-1:0]    idle;
    logic             last_q;
    logic             drain_wait;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             abort;
    logic             busy;

    // Scan from the highest offset down so the lowest offset from p wins.
    function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] v, input logic [PW-1:0] p);
        logic [PW-1:0] r;
        int            j;
        r = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(p) + k) % N_REQ;
            if (v[j]) r = PW'(j);
        end
        return r;
    endfunction

    assign pick     = rr_pick(bus.req_valid, rr_ptr);
    assign next_ptr = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ARB;
            rr_ptr     <= '0;
            owner      <= '0;
            grant      <= '0;
            idle       <= '0;
            last_q     <= 1'b0;
            drain_wait <= 1'b0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            abort      <= 1'b0;
        end else begin
            abort <= 1'b0;
            unique case (state)
                ARB: begin
                    if (bus.en && |bus.req_valid) begin
                        owner <= pick;
                        grant <= N_REQ'(1) << pick;
                        idle  <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (bus.req_valid[owner]) begin
                        tx_data  <= bus.req_data[{owner, 3'b000} +: 8];
                        last_q   <= bus.req_last[owner];
                        tx_valid <= 1'b1;
                        state    <= LOAD;
                    end else if (idle == CW'(TIMEOUT - 1)) begin
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                        abort  <= 1'b1;
                        state  <= ARB;
                    end else begin
                        idle <= idle + 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.tx_o_ready) begin
                        tx_valid   <= 1'b0;
                        drain_wait <= 1'b1;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    // uart_tx may keep ready high for one cycle after accepting.
                    if (drain_wait) begin
                        drain_wait <= 1'b0;
                    end else if (bus.tx_o_ready) begin
                        if (last_q || !bus.en) begin
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                            state  <= ARB;
                        end else begin
                            idle  <= '0;
                            state <= SEND;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    assign busy                = (state != ARB);
    assign bus.busy            = busy;
    assign bus.tx_en           = bus.en | busy;
    assign bus.req_ready       = (state == SEND) ? grant : '0;
    assign bus.grant           = grant;
    assign bus.tx_i_data       = tx_data;
    assign bus.tx_i_data_valid = tx_valid;
    assign bus.abort           = abort;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: requester queues, a uart_tx model and a
// transaction-level reference of grant ownership, byte flow and timeouts.
module tb_uart_tx_scheduler;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam int QD = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.N_REQ(N)) bus();
    uart_tx_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic [8:0] rmem [N][QD];
    int         rhead [N];
    int         rtail [N];
    int         stall [N];
    bit         rand_mode = 1'b0;
    logic [7:0] handed [$];
    logic [7:0] txlog [$];
    int         abort_cnt = 0;

    logic rdy = 1'b1;
    bit   lag = 1'b0;
    int   ucnt = 0;

    // reference: owner (-1 = none), offered, byte pending at uart, one blind cycle after take
    int         m_own = -1, m_ptr = 0, m_stall = 0;
    bit         m_offer = 0, m_pend = 0, m_blind = 0, m_last = 0, m_abt = 0;
    logic [7:0] m_txd = 8'h00;

    logic           s_rst, s_en, s_rdy, s_txv;
    logic [N-1:0]   s_v, s_l, s_rr;
    logic [8*N-1:0] s_d;
    logic [7:0]     s_txd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic last, input logic [7:0] d);
        rmem[i][rtail[i] % QD] = {last, d};
        rtail[i]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (rtail[i] > rhead[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic release_owner();
        m_ptr   = (m_own + 1) % N;
        m_own   = -1;
        m_offer = 1'b0;
    endtask

    task automatic model_edge();
        m_abt = 1'b0;
        if (!s_rst) begin
            m_own = -1; m_ptr = 0; m_offer = 0; m_pend = 0; m_blind = 0; m_last = 0; m_txd = 8'h00;
            return;
        end
        if (m_own < 0) begin
            if (s_en && s_v != '0) begin
                m_own = rr_pick(m_ptr, s_v); m_offer = 1'b1; m_stall = 0;
            end
        end else if (m_offer) begin
            if (s_v[m_own]) begin
                m_txd = s_d[8*m_own +: 8]; m_last = s_l[m_own]; m_offer = 1'b0; m_pend = 1'b1;
            end else begin
                m_stall++;
                if (m_stall == TO) begin m_abt = 1'b1; release_owner(); end
            end
        end else if (m_pend) begin
            if (s_rdy) begin m_pend = 1'b0; m_blind = 1'b1; end
        end else if (m_blind) begin
            m_blind = 1'b0;
        end else if (s_rdy) begin
            if (m_last || !s_en) release_owner();
            else begin m_offer = 1'b1; m_stall = 0; end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        eg = (m_own >= 0) ? N'(1) << m_own : '0;
        chk("grant",     32'(bus.grant),           32'(eg));
        chk("req_ready", 32'(bus.req_ready),       32'(m_offer ? eg : '0));
        chk("tx_valid",  32'(bus.tx_i_data_valid), 32'(m_pend));
        chk("tx_data",   32'(bus.tx_i_data),       32'(m_txd));
        chk("abort",     32'(bus.abort),           32'(m_abt));
        chk("busy",      32'(bus.busy),            32'(m_own >= 0));
        chk("tx_en",     32'(bus.tx_en),           32'(bus.en | (m_own >= 0)));
        if (bus.abort) abort_cnt++;
    endtask

    task automatic sample();
        s_rst = rst; s_en = bus.en; s_rdy = bus.tx_o_ready; s_txv = bus.tx_i_data_valid;
        s_v = bus.req_valid; s_l = bus.req_last; s_d = bus.req_data; s_rr = bus.req_ready;
        s_txd = bus.tx_i_data;
    endtask

    task automatic after_edge();
        if (s_rst) begin
            for (int i = 0; i < N; i++)
                if (s_v[i] && s_rr[i]) begin
                    handed.push_back(s_d[8*i +: 8]);
                    rhead[i]++;
                end
            if (s_txv && s_rdy) begin
                chk("handed_depth", 32'(handed.size()), 32'd1);
                if (handed.size() > 0) chk("tx_byte", 32'(s_txd), 32'(handed.pop_front()));
                txlog.push_back(s_txd);
            end
        end else begin
            handed.delete();
        end
        if (s_txv && s_rdy) begin
            ucnt = $urandom_range(2, 8);
            if ($urandom_range(0, 1) == 1) lag = 1'b1; else rdy = 1'b0;
        end else if (lag) begin
            lag = 1'b0; rdy = 1'b0;
        end else if (!rdy) begin
            ucnt--;
            if (ucnt == 0) rdy = 1'b1;
        end
    endtask

    task automatic drive();
        logic [8:0] w;
        for (int i = 0; i < N; i++) begin
            if (stall[i] > 0) stall[i]--;
            else if (rand_mode && $urandom_range(0, 19) == 0) stall[i] = $urandom_range(1, 12);
            w = (rtail[i] > rhead[i]) ? rmem[i][rhead[i] % QD] : 9'h000;
            bus.req_valid[i]        = (rtail[i] > rhead[i]) && (stall[i] == 0);
            bus.req_last[i]         = w[8];
            bus.req_data[8*i +: 8]  = w[7:0];
        end
        if (rand_mode && $urandom_range(0, 49) == 0) bus.en = ~bus.en;
        bus.tx_o_ready = rdy;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        sample();
        @(posedge clk);
        #1;
        after_edge();
        model_edge();
        drive();
    endtask

    task automatic run_idle(input string tag, input int bound);
        int n;
        n = 0;
        while ((pending() || m_own >= 0 || !rdy) && n < bound) begin cycle(); n++; end
        chk({tag, "_done"}, 32'(n < bound), 32'd1);
    endtask

    task automatic wait_owner(input string tag, input int who, input bit need_pend);
        int n;
        n = 0;
        while (!(m_own == who && (!need_pend || m_pend)) && n < 200) begin cycle(); n++; end
        chk({tag, "_wait"}, 32'(n < 200), 32'd1);
    endtask

    task automatic chk_log(input string tag, input logic [7:0] e [$]);
        chk({tag, "_len"}, 32'(txlog.size()), 32'(e.size()));
        for (int k = 0; k < e.size() && k < txlog.size(); k++) chk({tag, "_byte"}, 32'(txlog[k]), 32'(e[k]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] e [$];
        bus.en = 1'b0; bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_o_ready = 1'b1;
        for (int i = 0; i < N; i++) begin rhead[i] = 0; rtail[i] = 0; stall[i] = 0; end

        // all four hold one-byte packets from reset; requester 0 queues a second one
        for (int i = 0; i < N; i++) push(i, 1'b1, 8'(8'h10 + i));
        push(0, 1'b1, 8'h10);
        drive();
        repeat (3) cycle();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_data",  32'(bus.tx_i_data), 32'd0);
        chk("rst_valid", 32'(bus.tx_i_data_valid), 32'd0);
        chk("rst_tx_en", 32'(bus.tx_en), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_abort", 32'(bus.abort), 32'd0);
        rst = 1'b1; bus.en = 1'b1; txlog.delete();
        run_idle("A", 400);
        e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        chk_log("A", e);

        txlog.delete();
        push(0, 1'b0, 8'hAA); push(0, 1'b1, 8'h19);
        run_idle("B", 200);
        e = '{8'hAA, 8'h19};
        chk_log("B", e);

        txlog.delete();
        push(2, 1'b0, 8'h21); push(2, 1'b0, 8'h22); push(2, 1'b1, 8'h23);
        wait_owner("C", 2, 1'b0);
        push(1, 1'b1, 8'h5A);
        run_idle("C", 300);
        e = '{8'h21, 8'h22, 8'h23, 8'h5A};
        chk_log("C", e);

        txlog.delete(); abort_cnt = 0;
        push(1, 1'b0, 8'h31);
        wait_owner("D", 1, 1'b0);
        push(2, 1'b1, 8'h41);
        run_idle("D", 300);
        chk("D_aborts", 32'(abort_cnt), 32'd1);
        e = '{8'h31, 8'h41};
        chk_log("D", e);
        push(1, 1'b1, 8'h32);
        run_idle("D2", 200);

        txlog.delete();
        push(3, 1'b0, 8'h71); push(3, 1'b0, 8'h72); push(3, 1'b1, 8'h73);
        wait_owner("E", 3, 1'b1);
        bus.en = 1'b0;
        repeat (30) cycle();
        chk("E_grant", 32'(bus.grant), 32'd0);
        chk("E_busy",  32'(bus.busy), 32'd0);
        chk("E_tx_en", 32'(bus.tx_en), 32'd0);
        chk("E_sent",  32'(txlog.size()), 32'd1);
        bus.en = 1'b1;
        run_idle("E", 300);
        e = '{8'h71, 8'h72, 8'h73};
        chk_log("E", e);

        push(1, 1'b1, 8'h61);
        run_idle("F1", 200);
        push(2, 1'b1, 8'h62);
        wait_owner("F", 2, 1'b1);
        rst = 1'b0;
        cycle();
        chk("F_grant", 32'(bus.grant), 32'd0);
        chk("F_ready", 32'(bus.req_ready), 32'd0);
        chk("F_valid", 32'(bus.tx_i_data_valid), 32'd0);
        chk("F_data",  32'(bus.tx_i_data), 32'd0);
        chk("F_busy",  32'(bus.busy), 32'd0);
        rst = 1'b1;
        txlog.delete();
        push(3, 1'b1, 8'h83); push(0, 1'b1, 8'h80);
        run_idle("F", 300);
        e = '{8'h80, 8'h83};
        chk_log("F", e);

        rand_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++)
                if (rtail[i] - rhead[i] < 3 && $urandom_range(0, 7) == 0) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) push(i, b == len - 1, 8'($urandom));
                end
            cycle();
        end
        rand_mode = 1'b0;
        bus.en = 1'b1;
        run_idle("G", 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
